// File: rtl/scanline_prefetch.sv
// Double-buffered scanline cache: prefetches line y+1 from the frame store into one
// 320x16 buffer while line y is displayed as 8-bit pixels from the other.
module scanline_prefetch #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned V_TOTAL    = 525,
    parameter logic [19:0] FRAME_BASE = 20'h00000
) (
    input  logic        Clk,
    input  logic        Reset_N,
    input  logic        Pix_En,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    output logic        Mem_Req,
    output logic [19:0] Mem_Addr,
    input  logic        Mem_Ack,
    input  logic [15:0] Mem_Data,
    output logic [7:0]  Pixel_RGB,
    output logic        Underrun,
    input  logic        Clear_Underrun
);

    localparam int unsigned WORDS = H_ACTIVE / 2;
    localparam int unsigned WW    = $clog2(WORDS);
    localparam logic [WW-1:0] LAST_W = WW'(WORDS - 1);

    typedef enum logic [1:0] {StIdle, StReq, StGap} state_e;

    state_e          state_q, state_d;
    logic [9:0]      t_q, t_d;
    logic [WW-1:0]   w_q, w_d;
    logic            pend_q, pend_d;
    logic [9:0]      pend_t_q, pend_t_d;
    logic            underrun_q, underrun_d;
    logic [7:0]      pixel_q, pixel_d;

    logic [15:0]     line_buf0 [WORDS];
    logic [15:0]     line_buf1 [WORDS];

    logic [9:0]      trig_t;
    logic            trig;
    logic            wr_en;
    logic            visible;
    logic [WW-1:0]   rd_idx;
    logic [15:0]     rd_word;
    logic [19:0]     line_base;

    always_comb begin
        trig_t = (DrawY == 10'(V_TOTAL - 1)) ? 10'd0 : DrawY + 10'd1;
        trig   = Pix_En && (DrawX == 10'd0) && ((trig_t < 10'(V_ACTIVE)) || (trig_t == 10'd0));
    end

    assign line_base = FRAME_BASE + 20'(t_q) * 20'(WORDS);
    assign Mem_Req   = (state_q == StReq);
    assign Mem_Addr  = Mem_Req ? line_base + 20'(w_q) : 20'd0;
    assign wr_en     = Mem_Req && Mem_Ack;

    // A trigger during an outstanding request is parked until its ack arrives.
    always_comb begin
        state_d  = state_q;
        t_d      = t_q;
        w_d      = w_q;
        pend_d   = pend_q;
        pend_t_d = pend_t_q;
        unique case (state_q)
            StIdle: begin
                if (trig) begin
                    t_d     = trig_t;
                    w_d     = '0;
                    state_d = StReq;
                end
            end
            StReq: begin
                if (Mem_Ack) begin
                    pend_d = 1'b0;
                    if (trig) begin
                        t_d = trig_t;
                        w_d = '0;
                    end else if (pend_q) begin
                        t_d = pend_t_q;
                        w_d = '0;
                    end else if (w_q == LAST_W) begin
                        state_d = StIdle;
                    end else begin
                        w_d     = w_q + 1'b1;
                        state_d = StGap;
                    end
                end else if (trig) begin
                    pend_d   = 1'b1;
                    pend_t_d = trig_t;
                end
            end
            StGap: begin
                state_d = StReq;
                if (trig) begin
                    t_d = trig_t;
                    w_d = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Completing the final word in the same cycle as a new trigger is not a cut-short line.
    always_comb begin
        underrun_d = underrun_q;
        if (Clear_Underrun) underrun_d = 1'b0;
        if (trig && (state_q != StIdle) && !(wr_en && (w_q == LAST_W) && !pend_q)) begin
            underrun_d = 1'b1;
        end
    end

    always_comb begin
        visible = (DrawX < 10'(H_ACTIVE)) && (DrawY < 10'(V_ACTIVE));
        rd_idx  = visible ? WW'(DrawX >> 1) : '0;
        rd_word = DrawY[0] ? line_buf1[rd_idx] : line_buf0[rd_idx];
        pixel_d = 8'h00;
        if (visible) pixel_d = DrawX[0] ? rd_word[15:8] : rd_word[7:0];
    end

    always_ff @(posedge Clk) begin
        if (wr_en) begin
            if (t_q[0]) line_buf1[w_q] <= Mem_Data;
            else        line_buf0[w_q] <= Mem_Data;
        end
    end

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            state_q    <= StIdle;
            t_q        <= '0;
            w_q        <= '0;
            pend_q     <= 1'b0;
            pend_t_q   <= '0;
            underrun_q <= 1'b0;
            pixel_q    <= 8'h00;
        end else begin
            state_q    <= state_d;
            t_q        <= t_d;
            w_q        <= w_d;
            pend_q     <= pend_d;
            pend_t_q   <= pend_t_d;
            underrun_q <= underrun_d;
            pixel_q    <= pixel_d;
        end
    end

    assign Pixel_RGB = pixel_q;
    assign Underrun  = underrun_q;

endmodule

// File: tb/tb_scanline_prefetch.sv
// Bench for scanline_prefetch: latency-configurable memory responder, a word-level model of
// both line buffers, a per-cycle pixel/handshake checker and directed scenario checks.
module tb_scanline_prefetch;

    logic        Clk = 1'b0;
    logic        Reset_N = 1'b0;
    logic        Pix_En = 1'b0;
    logic [9:0]  DrawX = 10'd1;
    logic [9:0]  DrawY = 10'd0;
    logic        Mem_Req;
    logic [19:0] Mem_Addr;
    logic        Mem_Ack = 1'b0;
    logic [15:0] Mem_Data = 16'h0;
    logic [7:0]  Pixel_RGB;
    logic        Underrun;
    logic        Clear_Underrun = 1'b0;

    scanline_prefetch dut (
        .Clk            (Clk),
        .Reset_N        (Reset_N),
        .Pix_En         (Pix_En),
        .DrawX          (DrawX),
        .DrawY          (DrawY),
        .Mem_Req        (Mem_Req),
        .Mem_Addr       (Mem_Addr),
        .Mem_Ack        (Mem_Ack),
        .Mem_Data       (Mem_Data),
        .Pixel_RGB      (Pixel_RGB),
        .Underrun       (Underrun),
        .Clear_Underrun (Clear_Underrun)
    );

    always #10 Clk = ~Clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Memory responder: ack in the lat-th cycle of each request, data = address low half.
    int lat = 1;
    int rcnt = 0;
    always @(negedge Clk) begin
        if (!Reset_N || !Mem_Req) begin
            Mem_Ack = 1'b0;
            rcnt    = 0;
        end else begin
            if (Mem_Ack) rcnt = 0;
            rcnt++;
            Mem_Data = Mem_Addr[15:0];
            Mem_Ack  = (rcnt >= lat);
        end
    end

    // Model: each buffer word holds whatever the memory returned for its line/word slot.
    logic [15:0] model_buf [2][320];
    bit          known     [2][320];
    logic [19:0] ack_q [$];
    int          ack_cnt = 0;
    int          req_cycles = 0;
    bit          samp_ok = 0;
    bit          exp_known = 0;
    logic [7:0]  exp_pix = 8'h00;
    logic        prev_req = 1'b0;
    logic        prev_ack = 1'b0;
    logic [19:0] prev_addr = 20'h0;

    always @(posedge Clk) begin
        int b, wi, a;
        logic [15:0] word;
        samp_ok   = Reset_N;
        exp_known = 0;
        if (!Reset_N) begin
            for (int i = 0; i < 2; i++) for (int j = 0; j < 320; j++) known[i][j] = 0;
        end else begin
            if (DrawX < 640 && DrawY < 480) begin
                b  = int'(DrawY[0]);
                wi = int'(DrawX) / 2;
                if (known[b][wi]) begin
                    word      = model_buf[b][wi];
                    exp_pix   = DrawX[0] ? word[15:8] : word[7:0];
                    exp_known = 1;
                end
            end else begin
                exp_pix   = 8'h00;
                exp_known = 1;
            end
            if (Mem_Req) req_cycles++;
            if (Mem_Req && Mem_Ack) begin
                ack_q.push_back(Mem_Addr);
                ack_cnt++;
                a = int'(Mem_Addr);
                model_buf[(a / 320) % 2][a % 320] = Mem_Data;
                known[(a / 320) % 2][a % 320]     = 1;
            end
        end
        prev_req  = Mem_Req;
        prev_ack  = Mem_Ack;
        prev_addr = Mem_Addr;
    end

    always @(negedge Clk) begin
        if (samp_ok && Reset_N) begin
            if (exp_known) chk("pixel", 32'(Pixel_RGB), 32'(exp_pix));
            if (prev_req && !prev_ack) begin
                chk("req_hold", 32'(Mem_Req), 32'd1);
                chk("addr_hold", 32'(Mem_Addr), 32'(prev_addr));
            end
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge Clk);
    endtask

    task automatic trig(input int y);
        DrawX  = 10'd0;
        DrawY  = 10'(y);
        Pix_En = 1'b1;
        @(negedge Clk);
        Pix_En = 1'b0;
        DrawX  = 10'd1;
    endtask

    task automatic wait_acks(input string name, input int target, input int budget);
        for (int k = 0; k < budget && ack_cnt < target; k++) @(negedge Clk);
        chk(name, 32'(ack_cnt), 32'(target));
    endtask

    task automatic pix(input string name, input int x, input int y, input logic [7:0] exp);
        DrawX = 10'(x);
        DrawY = 10'(y);
        @(negedge Clk);
        chk(name, 32'(Pixel_RGB), 32'(exp));
    endtask

    task automatic sweep(input int y);
        for (int x = 0; x < 800; x++) begin
            DrawX = 10'(x);
            DrawY = 10'(y);
            @(negedge Clk);
        end
        DrawX = 10'd1;
    endtask

    task automatic check_line(input string name, input int first, input int base);
        int errs = 0;
        for (int i = 0; i < 320; i++) if (ack_q[first + i] !== 20'(base + i)) errs++;
        chk(name, 32'(errs), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, rc;
        tick(3);
        chk("rst_req", 32'(Mem_Req), 32'd0);
        chk("rst_addr", 32'(Mem_Addr), 32'd0);
        chk("rst_pix", 32'(Pixel_RGB), 32'd0);
        chk("rst_underrun", 32'(Underrun), 32'd0);
        Reset_N = 1'b1;
        tick(2);

        // Line 1 fetch with 1-cycle memory.
        lat = 1;
        c0 = ack_cnt;
        trig(0);
        chk("req_rise", 32'(Mem_Req), 32'd1);
        chk("first_addr", 32'(Mem_Addr), 32'd320);
        wait_acks("line1_acks", c0 + 320, 2000);
        chk("line1_done_req", 32'(Mem_Req), 32'd0);
        check_line("line1_seq", c0, 320);
        tick(3);
        chk("line1_idle", 32'(ack_cnt), 32'(c0 + 320));
        pix("l1_x0", 0, 1, 8'h40);
        pix("l1_x1", 1, 1, 8'h01);
        pix("l1_x638", 638, 1, 8'h7F);
        pix("l1_x639", 639, 1, 8'h02);
        pix("blank_x640", 640, 1, 8'h00);
        pix("blank_x799", 799, 1, 8'h00);
        pix("blank_y480", 5, 480, 8'h00);
        sweep(1);

        // Triggers for non-visible targets issue nothing; line 524 wraps to line 0.
        rc = req_cycles;
        for (int y = 479; y <= 523; y++) trig(y);
        tick(2);
        chk("vblank_no_req", 32'(req_cycles), 32'(rc));
        c0 = ack_cnt;
        trig(524);
        wait_acks("line0_acks", c0 + 320, 2000);
        check_line("line0_seq", c0, 0);
        tick(2);
        pix("l0_x2", 2, 0, 8'h01);
        pix("l0_x510", 510, 0, 8'hFF);
        pix("l0_x511", 511, 0, 8'h00);
        sweep(0);

        // Slow memory: retrigger mid-line abandons line 3 after its in-flight word.
        lat = 10;
        c0 = ack_cnt;
        trig(2);
        wait_acks("l3_part_acks", c0 + 5, 200);
        tick(2);
        chk("underrun_pre", 32'(Underrun), 32'd0);
        trig(3);
        chk("underrun_set", 32'(Underrun), 32'd1);
        wait_acks("inflight_acks", c0 + 7, 100);
        chk("inflight_addr", 32'(ack_q[c0 + 5]), 32'd965);
        chk("restart_addr", 32'(ack_q[c0 + 6]), 32'd1280);
        wait_acks("line4_acks", c0 + 6 + 320, 5000);
        check_line("line4_seq", c0 + 6, 1280);
        tick(2);
        pix("l3_x10", 10, 3, 8'hC5);
        pix("l3_x12", 12, 3, 8'h46);
        pix("l4_x1", 1, 4, 8'h05);
        sweep(3);
        sweep(4);

        // Underrun clear, then set and clear in the same cycle.
        Clear_Underrun = 1'b1;
        @(negedge Clk);
        Clear_Underrun = 1'b0;
        chk("underrun_clear", 32'(Underrun), 32'd0);
        trig(6);
        @(negedge Clk);
        DrawX = 10'd0;
        DrawY = 10'd7;
        Pix_En = 1'b1;
        Clear_Underrun = 1'b1;
        @(negedge Clk);
        Pix_En = 1'b0;
        Clear_Underrun = 1'b0;
        DrawX = 10'd1;
        chk("set_wins", 32'(Underrun), 32'd1);

        // Asynchronous reset in the middle of a request.
        chk("req_before_rst", 32'(Mem_Req), 32'd1);
        #2;
        Reset_N = 1'b0;
        #1;
        chk("rst_mid_req", 32'(Mem_Req), 32'd0);
        chk("rst_mid_addr", 32'(Mem_Addr), 32'd0);
        chk("rst_mid_pix", 32'(Pixel_RGB), 32'd0);
        chk("rst_mid_underrun", 32'(Underrun), 32'd0);
        tick(2);
        Reset_N = 1'b1;
        rc = req_cycles;
        c0 = ack_cnt;
        tick(20);
        chk("post_rst_no_req", 32'(req_cycles), 32'(rc));
        chk("post_rst_no_ack", 32'(ack_cnt), 32'(c0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
